// File: rtl/sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_bridge_if
// Purpose  : CPU-side request/response bundle for the 32-bit SRAM bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_bridge_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH:0]   req_addr;
    logic [3:0]            req_be;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_bridge
// Purpose  : Splits 32-bit load/store requests into two 16-bit async SRAM
//            accesses (low half first) and drives the active-low strobes.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bridge #(
    parameter int ADDR_WIDTH = 18,
    parameter int READ_WAIT  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    sram_bridge_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [15:0]           data,
    output logic                  wre,
    output logic                  oute,
    output logic                  hb_mask,
    output logic                  lb_mask,
    output logic                  chip_en
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_WS_LO = 3'd3,
        S_WE_LO = 3'd4,
        S_WS_HI = 3'd5,
        S_WE_HI = 3'd6,
        S_RESP  = 3'd7
    } state_t;

    localparam logic [1:0] c_rw_last = 2'(READ_WAIT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-2:0] word_q, word_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [15:0]           lo_q, lo_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  w_hi;
    logic                  w_drive;
    logic [15:0]           w_wr_half;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    word_d  = bus.req_addr[ADDR_WIDTH:2];
                    be_d    = bus.req_be;
                    wdata_d = bus.req_wdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (bus.req_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!bus.req_write) begin
                        state_d = S_RD_LO;
                    end else if (bus.req_be[1:0] != 2'b00) begin
                        state_d = S_WS_LO;
                    end else if (bus.req_be[3:2] != 2'b00) begin
                        state_d = S_WS_HI;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RD_LO: begin
                if (cnt_q == c_rw_last) begin
                    lo_d    = data;
                    cnt_d   = '0;
                    state_d = S_RD_HI;
                end else begin
                    cnt_d = 2'(cnt_q + 2'd1);
                end
            end
            // The visible load word only changes once both halves are in.
            S_RD_HI: begin
                if (cnt_q == c_rw_last) begin
                    rdata_d = {data, lo_q};
                    cnt_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = 2'(cnt_q + 2'd1);
                end
            end
            S_WS_LO: state_d = S_WE_LO;
            S_WE_LO: state_d = (be_q[3:2] != 2'b00) ? S_WS_HI : S_RESP;
            S_WS_HI: state_d = S_WE_HI;
            S_WE_HI: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset releases the SRAM bus in the same time step.
    always_comb begin
        chip_en = 1'b1;
        wre     = 1'b1;
        oute    = 1'b1;
        hb_mask = 1'b1;
        lb_mask = 1'b1;
        w_drive = 1'b0;
        w_hi    = 1'b0;
        case (state_q)
            S_RD_LO, S_RD_HI: begin
                chip_en = 1'b0;
                oute    = 1'b0;
                hb_mask = 1'b0;
                lb_mask = 1'b0;
                w_hi    = (state_q == S_RD_HI);
            end
            S_WS_LO, S_WE_LO: begin
                chip_en = 1'b0;
                w_drive = 1'b1;
                lb_mask = ~be_q[0];
                hb_mask = ~be_q[1];
                wre     = (state_q != S_WE_LO);
            end
            S_WS_HI, S_WE_HI: begin
                chip_en = 1'b0;
                w_drive = 1'b1;
                w_hi    = 1'b1;
                lb_mask = ~be_q[2];
                hb_mask = ~be_q[3];
                wre     = (state_q != S_WE_HI);
            end
            default: begin
                chip_en = 1'b1;
            end
        endcase
    end

    assign w_wr_half = w_hi ? wdata_q[31:16] : wdata_q[15:0];
    assign addr      = {word_q, w_hi};
    assign data      = w_drive ? w_wr_half : 16'hzzzz;

    assign bus.req_ready  = (state_q == S_IDLE) && !reset;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_err   = (state_q == S_RESP) && err_q;
    assign bus.resp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Memory-side stage between the Mips core's 32-bit load/store port and the 256K x 16 asynchronous SRAM model (Ram).
- Converts one 32-bit word request into two 16-bit SRAM accesses (low half first) and drives the active-low SRAM strobes.
- Returns read data or a write acknowledge over a valid/ready request and response handshake.

Parameters:
- ADDR_WIDTH, 18: SRAM half-word address width. The CPU byte address is ADDR_WIDTH+1 bits.
- READ_WAIT, 1: cycles that oute is held low per read half before sampling (range 1..4).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  bridge can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH+1  byte address; bits [1:0] must be 00
- req_be  in  4  byte enables for stores, bit0 = byte [7:0]; ignored for loads
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle pulse: response ready
- resp_rdata  out  32  load data; holds until the next load response
- resp_err  out  1  misaligned request; valid only with resp_valid
- addr  out  ADDR_WIDTH  SRAM half-word address
- data  inout  16  SRAM data; driven only in write phases, high-Z otherwise
- wre  out  1  write enable, active-low
- oute  out  1  output enable, active-low
- hb_mask  out  1  upper byte select, active-low
- lb_mask  out  1  lower byte select, active-low
- chip_en  out  1  chip enable, active-low

Behaviour:
- Reset values (take effect asynchronously):
  - FSM = IDLE; req_ready = 0 while reset is high, 1 after release.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - chip_en = wre = oute = hb_mask = lb_mask = 1; addr = 0; data = Z.
- Handshake:
  - A request is accepted on the edge where req_valid && req_ready. addr, be, wdata and write are captured at that edge.
  - Request inputs are ignored outside IDLE.
  - resp_valid pulses for exactly one cycle. The FSM returns to IDLE in the same cycle, so a new request can be accepted in the cycle after the pulse.
- Address mapping: low half at {req_addr[ADDR_WIDTH:2], 0}, high half at {req_addr[ADDR_WIDTH:2], 1}. Little-endian: low half carries word bits [15:0].
- FSM states: IDLE, RD_LO, RD_HI, WS_LO, WE_LO, WS_HI, WE_HI, RESP.
  - IDLE -> RESP with err = 1 if req_addr[1:0] != 0. No SRAM activity.
  - IDLE -> RD_LO for a load.
  - For a store: IDLE -> WS_LO if be[1:0] != 0; else WS_HI if be[3:2] != 0; else RESP with err = 0 and no SRAM activity.
- Read phases (RD_LO, RD_HI):
  - chip_en = 0, oute = 0, hb_mask = lb_mask = 0, wre = 1; each phase lasts READ_WAIT cycles.
  - data is sampled on the final edge of the phase into the matching half of resp_rdata.
  - RD_LO -> RD_HI -> RESP.
- Write setup (WS_*): chip_en = 0, addr and data driven, byte masks set from the be pair, wre = 1, oute = 1.
- Write strobe (WE_*): same as setup but wre = 0 for exactly one cycle. addr, data and masks are stable across the setup and strobe cycles.
- Write sequencing:
  - WE_LO -> WS_HI if be[3:2] != 0, else RESP.
  - WE_HI -> RESP.
- Byte masks: lb_mask = ~be[0], hb_mask = ~be[1] for the low half; lb_mask = ~be[2], hb_mask = ~be[3] for the high half.
- RESP: resp_valid = 1 for one cycle and all SRAM strobes are deasserted.
- Latency with READ_WAIT = 1:
  - Load: accept edge, RD_LO, RD_HI, then resp_valid in the 3rd cycle after accept.
  - Full store: resp_valid in the 5th cycle.
  - Single-half store: resp_valid in the 3rd cycle.
- Safety rules:
  - oute and wre are never low together.
  - data is released (high-Z) in the cycle a read or IDLE begins.
- Reset mid-operation: all strobes deassert and data goes high-Z immediately. The in-flight request is dropped with no response.

Test Plan:
- Load, READ_WAIT = 1: preload SRAM[0x10] = 0xBEEF, SRAM[0x11] = 0xDEAD; load addr 0x20 -> resp_valid 3 cycles after accept, resp_rdata = 0xDEADBEEF, resp_err = 0.
- Full store then load: store 0x12345678 to addr 0x40 with be = 1111 -> wre low exactly 2 cycles total, SRAM[0x20] = 0x5678, SRAM[0x21] = 0x1234; reload returns 0x12345678.
- Partial store: be = 0100, wdata = 0x00AB0000 to addr 0x40 over 0x12345678 -> only WS_HI/WE_HI run, lb_mask = 0, hb_mask = 1, SRAM[0x21] = 0x12AB; resp 3 cycles after accept.
- Misaligned and empty: load addr 0x22 -> resp_err = 1 next cycle, chip_en never low; store be = 0000 -> resp_err = 0, no SRAM activity.
- Reset mid-write: assert reset during WE_LO -> wre and chip_en go high and data goes high-Z within the same time step; req_ready = 1 after release; no resp_valid.
- Back-to-back: keep req_valid high with three loads -> each accepted in the cycle after the previous resp_valid pulse; oute and wre never low together throughout.
